mem_dma: RTL
============

Name: mem_dma

Overview:
- Initiator-side engine for the single-port synchronous data memory (24-bit words, 1-cycle registered read).
- Drives the memory's write-enable, address and write-data pins and consumes its read-data output.
- Performs block copy (memory to memory) or block fill (constant to memory) on a start/done handshake.
- Sits beside the core as a secondary memory master; arbitration is external.

Parameters:
- P_RD_LATENCY, 1, memory read latency in cycles (legal 1..3); sets how many cycles CAPTURE waits before read data is sampled.

Ports:
- iw_clk  in  1  clock; all state changes on rising edge.
- iw_rst  in  1  reset, synchronous, active-high.
- iw_start  in  1  start request, sampled only in IDLE.
- iw_abort  in  1  abort current transfer; returns to IDLE with no done pulse.
- iw_fill  in  1  mode at start: 0 = copy, 1 = fill.
- iw_src  in  `HBIT_ADDR+1  source base address (copy mode).
- iw_dst  in  `HBIT_ADDR+1  destination base address.
- iw_len  in  `HBIT_ADDR+1  word count.
- iw_fill_data  in  `HBIT_DATA+1  fill value (fill mode).
- or_busy  out  1  transfer in progress.
- or_done  out  1  one-cycle completion pulse.
- or_mem_we  out  1  memory write enable.
- or_mem_addr  out  `HBIT_ADDR+1  memory address.
- or_mem_wdata  out  `HBIT_DATA+1  memory write data.
- iw_mem_rdata  in  `HBIT_DATA+1  memory read data.

Behaviour:
- All outputs are registered.
- Reset values: or_busy=0, or_done=0, or_mem_we=0, or_mem_addr=0, or_mem_wdata=0. State=IDLE, index=0.
- States: IDLE, RD, CAPTURE, WR, DONE.
- Start: at an edge in IDLE with iw_start=1, latch src, dst, len, fill mode and fill data. Later changes on these inputs are ignored until return to IDLE.
- Start with len=0: go to DONE; no memory access at all.
- Copy word i:
  - RD (1 cycle): addr=src+i, we=0.
  - CAPTURE (P_RD_LATENCY cycles): we=0, addr held. Sample iw_mem_rdata on the last CAPTURE edge.
  - WR (1 cycle): we=1, addr=dst+i, wdata=sampled data.
  - Cost per word: 2+P_RD_LATENCY cycles.
- Fill word i: WR only; we=1, addr=dst+i, wdata=fill data. Cost: 1 cycle per word, back-to-back.
- After WR: i increments. If i+1==len go to DONE, else go to RD (copy) or stay in WR (fill).
- or_busy is 1 in RD, CAPTURE and WR. It is 0 in IDLE and DONE.
- DONE lasts exactly 1 cycle: or_done=1, we=0, then IDLE.
- Timing, start sampled at edge k, with P_RD_LATENCY=1:
  - Copy N words: busy during cycles k+1 .. k+3N; done during cycle k+3N+1.
  - Fill: busy k+1 .. k+N; done k+N+1.
- we is never 1 outside WR.
- Address arithmetic is modulo 2^(`HBIT_ADDR+1); src+i and dst+i wrap silently. len is not clamped.
- Order is strictly ascending. An overlapping copy with dst>src reads already-written words; this is by design.
- iw_start while busy: ignored.
- iw_start and iw_abort together in IDLE: abort wins; no transfer starts.
- iw_abort in any non-IDLE state:
  - Next state is IDLE; we=0, busy=0 from the next cycle; no done pulse.
  - If abort is sampled at the edge that ends a WR cycle, that write still lands, since the memory samples we on that same edge.
- iw_abort in DONE: the done pulse is already visible; go to IDLE normally.
- iw_rst mid-transfer: identical to abort, plus all outputs return to reset values at that edge.

Decomposition:
- Widths come from the existing shared src2/sizes.vh (`HBIT_ADDR, `HBIT_DATA).
- New header src2/mem_dma.vh holds the state encodings (3-bit localparams) and the mode constants (copy=0, fill=1). The arbiter and bench reuse these.
- No sub-module is required. A single FSM with index and latency counters fits in about 200 lines.
- Bench instantiates the existing memory block as the responder.

Test Plan:
- Copy: preload mem[0x010..0x013]=0xA00001..0xA00004. Start copy, src=0x010, dst=0x100, len=4 -> mem[0x100..0x103] match. busy high 12 cycles, done 1 cycle at k+13. we asserted exactly 4 cycles.
- Fill: dst=0x200, len=3, fill=0x5A5A5A -> mem[0x200..0x202]=0x5A5A5A, mem[0x203] untouched. done at k+4.
- len=0 -> done at k+1, busy never high, we never high, memory unchanged.
- Wrap: fill with dst=max address-1, len=3 -> words written at max-1, max, 0.
- Abort: start copy len=8, assert iw_abort during word 2's CAPTURE -> exactly 2 words written, no done pulse, busy low next cycle. A new start then works.
- Start while busy, plus reset during WR: second start ignored (len unchanged). iw_rst at a WR edge -> all outputs 0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared widths, FSM state encoding and mode constants for the
// block-copy / block-fill memory DMA engine and anything that talks to it.
package mem_dma_pkg;

  localparam int unsigned ADDR_W = 12;  // data memory address width
  localparam int unsigned DATA_W = 24;  // data memory word width

  // Transfer mode as latched at start
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_CAPTURE = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/mem_dma.sv
// mem_dma: secondary initiator on the single-port synchronous data memory.
// Performs block copy (mem -> mem) or block fill (constant -> mem) in strictly
// ascending address order on a start/done handshake.
//
// Ports:
//   iw_clk, iw_rst      clock, synchronous active-high reset
//   iw_start            start request (sampled only in IDLE)
//   iw_abort            abort; back to IDLE without a done pulse (wins over start)
//   iw_fill             mode at start: 0 = copy, 1 = fill
//   iw_src/iw_dst       source / destination base address
//   iw_len              word count (0 = immediate done, no access)
//   iw_fill_data        fill value
//   or_busy, or_done    transfer in progress / one-cycle completion pulse
//   or_mem_we/addr/wdata  memory write enable, address, write data
//   iw_mem_rdata        memory read data (P_RD_LATENCY cycles after address)
//
// All outputs are registered; the combinational block computes the value each
// output takes in the *next* state.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int unsigned P_RD_LATENCY = 1
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_start,
  input  logic              iw_abort,
  input  logic              iw_fill,
  input  logic [ADDR_W-1:0] iw_src,
  input  logic [ADDR_W-1:0] iw_dst,
  input  logic [ADDR_W-1:0] iw_len,
  input  logic [DATA_W-1:0] iw_fill_data,
  output logic              or_busy,
  output logic              or_done,
  output logic              or_mem_we,
  output logic [ADDR_W-1:0] or_mem_addr,
  output logic [DATA_W-1:0] or_mem_wdata,
  input  logic [DATA_W-1:0] iw_mem_rdata
);

  // CAPTURE counts down from this value; data is sampled when it reaches 0
  localparam logic [1:0] LAT_LAST = 2'(P_RD_LATENCY - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;
  logic [1:0]        lat_q, lat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [ADDR_W-1:0] idx_nxt;
  assign idx_nxt = idx_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    fdata_d = fdata_q;
    lat_d   = lat_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (iw_start && !iw_abort) begin
          src_d   = iw_src;
          dst_d   = iw_dst;
          len_d   = iw_len;
          mode_d  = iw_fill;
          fdata_d = iw_fill_data;
          idx_d   = '0;
          if (iw_len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (iw_fill == MODE_FILL) begin
            state_d = S_WR;
            busy_d  = 1'b1;
            we_d    = 1'b1;
            addr_d  = iw_dst;
            wdata_d = iw_fill_data;
          end else begin
            state_d = S_RD;
            busy_d  = 1'b1;
            addr_d  = iw_src;
          end
        end
      end

      S_RD: begin
        state_d = S_CAPTURE;
        busy_d  = 1'b1;
        lat_d   = LAT_LAST;
      end

      S_CAPTURE: begin
        busy_d = 1'b1;
        if (lat_q == '0) begin
          state_d = S_WR;
          we_d    = 1'b1;
          addr_d  = dst_q + idx_q;
          wdata_d = iw_mem_rdata;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end

      S_WR: begin
        if (idx_nxt == len_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d  = idx_nxt;
          busy_d = 1'b1;
          if (mode_q == MODE_FILL) begin
            we_d   = 1'b1;
            addr_d = dst_q + idx_nxt;
          end else begin
            state_d = S_RD;
            addr_d  = src_q + idx_nxt;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides whatever the state decoded; a write in flight on this
    // edge is still seen by the memory because we_q is only cleared after it.
    if (iw_abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      we_d    = 1'b0;
    end
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      mode_q  <= MODE_COPY;
      fdata_q <= '0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      fdata_q <= fdata_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign or_busy      = busy_q;
  assign or_done      = done_q;
  assign or_mem_we    = we_q;
  assign or_mem_addr  = addr_q;
  assign or_mem_wdata = wdata_q;

endmodule
